// File: rtl/core_pkg.sv
// Shared constants for the 3-stage RISC-V core: NOP encoding, boot address,
// base opcodes, fetch state encoding and a PC alignment helper.
package core_pkg;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h4000_0000;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [1:0] FS_BOOT = 2'd0;
    localparam logic [1:0] FS_RUN  = 2'd1;
    localparam logic [1:0] FS_HOLD = 2'd2;

    // Instruction addresses are word aligned; low target bits are dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bundle: pipeline control in, instruction-memory port, IF/ID slot out.
interface if_stage_if;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] dec_pc;
    logic [31:0] dec_inst;
    logic        dec_valid;
    logic [6:0]  dec_opcode;
    logic [2:0]  dec_funct3;
    logic        dec_imm30;

    modport master (
        input  stall, redirect_valid, redirect_pc, imem_rdata,
        output imem_addr, dec_pc, dec_inst, dec_valid, dec_opcode, dec_funct3, dec_imm30
    );

    modport slave (
        output stall, redirect_valid, redirect_pc, imem_rdata,
        input  imem_addr, dec_pc, dec_inst, dec_valid, dec_opcode, dec_funct3, dec_imm30
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch: owns the fetch PC, drives synchronous IMEM and presents the
// IF/ID slot with stall hold, redirect squash and a one-cycle boot bubble.
module if_stage
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic      clk,
    input  logic      rst,
    if_stage_if.master bus
);

    logic [31:0] fetch_pc_r;
    logic [31:0] dec_pc_r;
    logic [31:0] hold_inst_r;
    logic        hold_valid_r;
    logic        squash_r;
    logic [1:0]  state_r;

    logic [31:0] slot_inst_s;
    logic [31:0] dec_inst_s;
    logic        dec_valid_s;

    assign slot_inst_s = squash_r ? NOP_INST : bus.imem_rdata;

    // PC sequencing, redirect/stall handling and the hold buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_r   <= RESET_PC;
            dec_pc_r     <= 32'h0000_0000;
            hold_inst_r  <= NOP_INST;
            hold_valid_r <= 1'b0;
            squash_r     <= 1'b1;
            state_r      <= FS_BOOT;
        end else if (bus.redirect_valid) begin
            // Data returning next cycle is wrong-path; squash it.
            fetch_pc_r <= align_pc(bus.redirect_pc);
            dec_pc_r   <= fetch_pc_r;
            squash_r   <= 1'b1;
            state_r    <= FS_RUN;
        end else begin
            case (state_r)
                FS_BOOT: begin
                    fetch_pc_r <= fetch_pc_r + 32'd4;
                    dec_pc_r   <= fetch_pc_r;
                    squash_r   <= 1'b0;
                    state_r    <= FS_RUN;
                end
                FS_RUN: begin
                    if (bus.stall) begin
                        // While held, IMEM re-reads fetch_pc, which is correct-path.
                        hold_inst_r  <= slot_inst_s;
                        hold_valid_r <= ~squash_r;
                        squash_r     <= 1'b0;
                        state_r      <= FS_HOLD;
                    end else begin
                        fetch_pc_r <= fetch_pc_r + 32'd4;
                        dec_pc_r   <= fetch_pc_r;
                        squash_r   <= 1'b0;
                    end
                end
                FS_HOLD: begin
                    if (!bus.stall) begin
                        fetch_pc_r <= fetch_pc_r + 32'd4;
                        dec_pc_r   <= fetch_pc_r;
                        squash_r   <= 1'b0;
                        state_r    <= FS_RUN;
                    end
                end
                default: begin
                    fetch_pc_r <= RESET_PC;
                    squash_r   <= 1'b1;
                    state_r    <= FS_BOOT;
                end
            endcase
        end
    end

    // Slot contents: held copy during HOLD, otherwise the (possibly squashed) read data.
    always_comb begin
        dec_inst_s  = NOP_INST;
        dec_valid_s = 1'b0;
        if (state_r == FS_HOLD) begin
            dec_inst_s  = hold_inst_r;
            dec_valid_s = hold_valid_r;
        end else begin
            dec_inst_s  = slot_inst_s;
            dec_valid_s = ~squash_r;
        end
    end

    assign bus.imem_addr  = fetch_pc_r;
    assign bus.dec_pc     = dec_pc_r;
    assign bus.dec_inst   = dec_inst_s;
    assign bus.dec_valid  = dec_valid_s;
    assign bus.dec_opcode = dec_inst_s[6:0];
    assign bus.dec_funct3 = dec_inst_s[14:12];
    assign bus.dec_imm30  = dec_inst_s[30];

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 3-stage RISC-V core; sits directly upstream of the control unit and decode.
- Owns the fetch PC and drives the synchronous-read instruction memory (BIOS/IMEM).
- Registers the returned instruction into the IF/ID slot and presents opcode, funct3 and inst[30] to the control unit.
- Handles stall hold, redirect squash and the post-reset boot bubble.

Parameters:
- RESET_PC, 32'h4000_0000, first fetch address after reset (BIOS base).
- NOP_INST, 32'h0000_0013, instruction injected into squashed or invalid slots (addi x0,x0,0).

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hold IF and the IF/ID slot this cycle.
- redirect_valid  input  1  taken branch/jal/jalr resolved this cycle.
- redirect_pc  input  32  redirect target.
- imem_addr  output  32  byte address to instruction memory; read data returns the next cycle.
- imem_rdata  input  32  synchronous read data for the previous cycle's imem_addr.
- dec_pc  output  32  PC of the instruction in the IF/ID slot.
- dec_inst  output  32  instruction in the IF/ID slot; NOP_INST when dec_valid=0.
- dec_valid  output  1  slot holds a real instruction.
- dec_opcode  output  7  dec_inst[6:0], to control unit inst.
- dec_funct3  output  3  dec_inst[14:12], to control unit imm.
- dec_imm30  output  1  dec_inst[30], to control unit imm30.

Behaviour:
- Registers:
  - fetch_pc[31:0]
  - dec_pc[31:0]
  - hold_inst[31:0]
  - squash (1 bit)
  - state in {BOOT, RUN, HOLD}
- Memory address and reset:
  - imem_addr = fetch_pc (registered; no combinational path from the redirect inputs to memory).
  - On rst: fetch_pc=RESET_PC, dec_pc=0, hold_inst=NOP_INST, squash=1, state=BOOT.
  - On rst, outputs are: dec_valid=0, dec_inst=NOP_INST, dec_opcode=7'h13, dec_funct3=0, dec_imm30=0.
  - Reset mid-stall or mid-redirect discards all in-flight state.
- BOOT, the first cycle after reset:
  - imem_addr=RESET_PC; slot invalid.
  - Next cycle: fetch_pc=RESET_PC+4, dec_pc=RESET_PC, squash=0, state=RUN.
  - stall in BOOT is ignored; the slot holds nothing.
- RUN without stall or redirect:
  - fetch_pc += 4, with 32-bit wrap-around (32'hFFFF_FFFC+4 = 0).
  - dec_pc <= fetch_pc.
  - dec_inst = squash ? NOP_INST : imem_rdata.
  - dec_valid = ~squash. After the edge, squash <= 0.
- Redirect (redirect_valid=1) in any non-reset state; redirect has priority over stall:
  - fetch_pc <= {redirect_pc[31:2],2'b00}; misaligned low bits are dropped.
  - squash <= 1; state <= RUN.
  - The data returning next cycle is from the wrong path and is shown as NOP with dec_valid=0.
  - The target instruction appears in the slot two cycles after redirect_valid, giving exactly one bubble.
  - Back-to-back redirects: the last one wins; each re-arms squash.
- Stall (stall=1, redirect_valid=0) in RUN:
  - fetch_pc and dec_pc hold.
  - hold_inst <= (squash ? NOP_INST : imem_rdata); squash is captured into the held valid bit.
  - state <= HOLD. dec_inst keeps showing the same slot value this cycle.
- HOLD:
  - dec_inst = hold_inst; dec_valid is the held valid bit.
  - fetch_pc still holds, so imem_rdata re-reads fetch_pc each cycle.
  - On stall deassert: state <= RUN and normal advance resumes the same cycle.
  - The instruction after the held one is therefore fetch_pc's data, with none lost or duplicated.
- Outputs in all states: dec_opcode, dec_funct3 and dec_imm30 are pure slices of dec_inst.
- Slot latency: an instruction at PC p is valid in the slot one cycle after imem_addr=p.

Decomposition:
- Shared package (core_pkg) holds:
  - NOP_INST
  - RESET_PC default
  - opcode localparams (OPC_R=7'b0110011, OPC_LOAD, OPC_BRANCH, OPC_OPIMM, OPC_JALR, OPC_STORE, OPC_JAL)
  - fetch state encoding
- No sub-module; the PC/redirect mux and the hold buffer are each small enough to stay inline.

Test Plan:
- Reset release, no stall, memory returns inst=addr^32'hA5A5_0000: cycle 1 slot invalid; cycle 2 dec_pc=32'h4000_0000, dec_valid=1; dec_pc advances by 4 each cycle.
- Redirect at cycle 5 to 32'h1000_0006: cycle 6 dec_valid=0 and dec_inst=32'h13; cycle 7 dec_pc=32'h1000_0004, valid.
- Stall for 3 cycles with dec_pc=32'h4000_0008: dec_pc and dec_inst are stable for all 3 cycles; after release the next slot is 32'h4000_000C with no skip or repeat.
- stall=1 and redirect_valid=1 in the same cycle to 32'h2000_0000: redirect wins; next slot invalid; then 32'h2000_0000.
- Stall asserted on the bubble cycle right after a redirect: held slot stays dec_valid=0 throughout; the target still arrives on the first cycle after release.
- Redirect to 32'hFFFF_FFFC with no stall: slots show FFFF_FFFC, then 0000_0000 (wrap), then 0000_0004. Assert rst mid-stall: next cycle after reset release is BOOT with fetch at RESET_PC.
